// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide,
// plus MTHI/MTLO writes and a stall request for HI/LO consumers while busy.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hilo_rd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   rs_raw_q, rs_raw_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               is_mul, is_dv, signed_op, is_grp;
    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem;

    // Funct groups: mul/div ops are 0110xx, move ops are 0100xx.
    assign is_mul    = (funct == F_MULT) || (funct == F_MULTU);
    assign is_dv     = (funct == F_DIV)  || (funct == F_DIVU);
    assign is_grp    = (funct[5:4] == 2'b01) && !funct[2];
    assign signed_op = !funct[0];
    assign rs_neg    = signed_op && rs_val[WIDTH-1];
    assign rt_neg    = signed_op && rt_val[WIDTH-1];
    assign rs_mag    = rs_neg ? ('0 - rs_val) : rs_val;
    assign rt_mag    = rt_neg ? ('0 - rt_val) : rt_val;

    // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    assign prod_fix  = neg_q ? ('0 - acc_q) : acc_q;
    assign quo       = acc_q[WIDTH-1:0];
    assign rem       = acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        rs_raw_d  = rs_raw_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && (is_mul || is_dv)) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    is_div_d  = is_dv;
                    rs_raw_d  = rs_val;
                    neg_d     = rs_neg ^ rt_neg;
                    neg_rem_d = rs_neg;
                    if (is_dv) begin
                        acc_d  = {{WIDTH{1'b0}}, rs_mag};
                        opnd_d = rt_mag;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, rt_mag};
                        opnd_d = rs_mag;
                    end
                end else if (req_valid && funct == F_MTHI) begin
                    hi_d = rs_val;
                end else if (req_valid && funct == F_MTLO) begin
                    lo_d = rs_val;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    if (!div_trial[WIDTH])
                        acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1))
                    state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (opnd_q == '0) begin
                    // Divide by zero: raw dividend in HI, no sign correction.
                    hi_d = rs_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = neg_rem_q ? ('0 - rem) : rem;
                    lo_d = neg_q ? ('0 - quo) : quo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            rs_raw_q  <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            rs_raw_q  <= rs_raw_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign stall   = req_valid && busy && is_grp;
    assign hilo_rd = (funct == F_MFHI) ? hi_q : lo_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed HI/LO results, latency,
// done pulse, stall behaviour and asynchronous reset mid-operation.
module tb_muldiv_sequencer;
  localparam int W = 32;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010,
                         F_MTLO = 6'b010011, F_MULT = 6'b011000, F_MULTU = 6'b011001,
                         F_DIV = 6'b011010, F_DIVU = 6'b011011;

  logic         clk, rst_n, req_valid;
  logic [5:0]   funct;
  logic [W-1:0] rs_val, rt_val;
  logic         busy, done, stall;
  logic [W-1:0] hilo_rd, hi, lo;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done), .stall(stall),
    .hilo_rd(hilo_rd), .hi(hi), .lo(lo)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single edge, then release req_valid.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    req_valid = 1'b1; funct = f; rs_val = a; rt_val = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Count busy cycles (sampled on negedges) until busy drops, bounded.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo);
    int cyc;
    issue(f, a, b);
    wait_idle(cyc);
    check({tag, "_latency"}, 64'(cyc), 64'd33);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int cyc, stall_bad;
    rst_n = 1'b0; req_valid = 1'b0; funct = '0; rs_val = '0; rt_val = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;

    run_op("mult_neg3x5", F_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_m7_2", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_7_m2", F_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    run_op("div_min_m1", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    run_op("divu_by0", F_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF);
    run_op("div_neg_by0", F_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("mult_m1xm1", F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1);

    // MFHI/MFLO read path from the registers
    @(negedge clk);
    funct = F_MFHI;
    #1 check("mfhi_rd", 64'(hilo_rd), 64'd0);
    funct = F_MFLO;
    #1 check("mflo_rd", 64'(hilo_rd), 64'd1);

    // MULT 6x7 with a second MULT, then MFLO, held under stall while busy
    issue(F_MULT, 32'd6, 32'd7);
    req_valid = 1'b1; funct = F_MULT; rs_val = 32'd3; rt_val = 32'd3;
    cyc = 0; stall_bad = 0;
    @(negedge clk);
    while (busy && cyc < 100) begin
      if (cyc == 12) funct = F_MFLO;
      if (stall !== 1'b1) stall_bad++;
      cyc++;
      @(negedge clk);
    end
    check("stall_latency", 64'(cyc), 64'd33);
    check("stall_while_busy", 64'(stall_bad), 64'd0);
    check("stall_released", 64'(stall), 64'd0);
    check("mflo_after_fin", 64'(hilo_rd), 64'd42);
    // re-presented MULT is accepted now that the unit is idle
    funct = F_MULT;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_idle(cyc);
    check("mult3x3_latency", 64'(cyc), 64'd33);
    check("mult3x3_lo", 64'(lo), 64'd9);

    // MTHI while busy is stalled and never written
    issue(F_MULTU, 32'd2, 32'd3);
    req_valid = 1'b1; funct = F_MTHI; rs_val = 32'hDEADBEEF;
    @(negedge clk);
    check("mthi_busy_stall", 64'(stall), 64'd1);
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    wait_idle(cyc);
    check("mthi_busy_hi", 64'(hi), 64'd0);
    check("mthi_busy_lo", 64'(lo), 64'd6);

    // asynchronous reset in the middle of a run
    issue(F_MULT, 32'd11, 32'd13);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(F_MTLO, 32'hA5A5A5A5, 32'd0);
    check("mtlo_lo", 64'(lo), 64'hA5A5A5A5);
    check("mtlo_busy", 64'(busy), 64'd0);
    issue(F_MTHI, 32'h5A5A0001, 32'd0);
    check("mthi_hi", 64'(hi), 64'h5A5A0001);
    @(negedge clk);
    check("mthi_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit with its own sequencer, sitting beside the EX-stage ALU.
- Executes the MIPS R-type HI/LO group: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Accepted operations run iteratively: shift-add for multiply, restoring division for divide.
- Asserts a stall to hold the pipeline while a HI/LO consumer or a new mul/div op meets a busy unit.

Parameters:
- WIDTH, 32, operand, HI and LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  EX stage holds an R-type instruction this cycle.
- funct  in  6  R-type funct field.
- rs_val  in  WIDTH  dividend, multiplicand or MTHI/MTLO source.
- rt_val  in  WIDTH  divisor or multiplier.
- busy  out  1  sequencer not in IDLE.
- done  out  1  one-cycle pulse, high the cycle after HI/LO are written by MULT/DIV.
- stall  out  1  combinational pipeline hold request.
- hilo_rd  out  WIDTH  combinational: HI when funct = MFHI, otherwise LO.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Funct codes: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011. Every other funct is ignored.
- Reset (asynchronous, any state, including mid-operation): state IDLE; hi, lo, counter and internal accumulators cleared to 0; busy = 0, done = 0.
- States: IDLE, RUN, FIN.
- IDLE:
  - req_valid with MULT/MULTU/DIV/DIVU at edge T0 latches operands (magnitudes for the signed ops, plus result-sign flags), clears the counter and moves to RUN.
  - MTHI/MTLO writes rs_val into hi/lo at the edge and stays in IDLE.
- RUN: one iteration per edge, T1..T32 (WIDTH edges). At T32 the state moves to FIN.
- FIN, edge T33:
  - Sign correction is applied and hi/lo are written; the state returns to IDLE; done = 1 for the following cycle.
- Busy window: busy is high for the cycles after T0 through T33, i.e. 33 cycles for WIDTH = 32. An op presented the cycle after done is accepted normally.
- Multiply: 2*WIDTH-bit unsigned product of the magnitudes; for MULT, negate the full product if operand signs differ. hi = upper half, lo = lower half.
- Divide: unsigned restoring division of the magnitudes.
  - DIV quotient is negative if the operand signs differ.
  - DIV remainder takes the sign of the dividend (truncating division). lo = quotient, hi = remainder.
- Divide by zero (DIV or DIVU): normal latency; lo = all ones, hi = rs_val unmodified, no sign correction.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- stall = req_valid & busy & (funct is any of the eight HI/LO-group codes). It is deasserted in the cycle in which busy is low.
- Requests arriving while busy are never latched; the pipeline re-presents them under stall.
- hilo_rd reflects the hi/lo register values only, with no bypass of in-flight results.
- MTHI/MTLO while busy: stalled, no write.

Test Plan:
- Reset, then MULT rs = 0xFFFFFFFD (-3), rt = 5 -> busy high 33 cycles; done pulses; hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001. Then DIVU 100 / 7 -> lo = 14, hi = 2.
- DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 7 / -2 -> lo = 0xFFFFFFFD, hi = 1. DIV 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
- DIVU 0x1234 / 0 -> lo = 0xFFFFFFFF, hi = 0x1234, 33-cycle latency.
- MULT 6 x 7, then MFLO held on req_valid -> stall high every busy cycle; stall low the cycle after the FIN edge with hilo_rd = 42. A second MULT presented mid-op is not latched until busy falls.
- Drop rst_n at RUN iteration 10 -> busy, done, hi, lo = 0 immediately. After release, MTLO rs = 0xA5A5A5A5 -> lo = 0xA5A5A5A5 next cycle, busy stays 0.
